// File: rtl/mips_pkg.sv
// Shared opcodes, FSM states and ALU encoding for the multicycle MIPS core.
// MIPS_MC_ADDI_EN adds the IEXEC/IWB states used by addi.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BEQEX, JEX
`ifdef MIPS_MC_ADDI_EN
    , IEXEC, IWB
`endif
  } state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    unique case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'h0, $signed(a) < $signed(b)};
      default: y = a + b;
    endcase
    return y;
  endfunction
endpackage

// File: rtl/mips_regfile.sv
// Register file: two async read ports, one sync write port, r0 hardwired to zero.
module mips_regfile #(
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [31:0]   rdata1,
  output logic [31:0]   rdata2
);
  logic [NUM_REGS-1:0][31:0] regs;

  // No reset on purpose: contents are undefined until software writes them.
  always_ff @(posedge clk)
    if (we && waddr != '0) regs[waddr] <= wdata;

  assign rdata1 = (raddr1 == '0) ? 32'h0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? 32'h0 : regs[raddr2];
endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS32 subset over one shared instruction/data memory port.
// Define MIPS_MC_ADDI_EN to execute addi; otherwise opcode 0x08 is illegal.
module mips_multicycle import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        illegal
);
  localparam int AW = $clog2(NUM_REGS);

  state_e        state, state_nx, dec_nx;
  logic [31:0]   ir, a_q, b_q, alu_out, mdr;
  logic [31:0]   rd1, rd2, sext, rf_wdata;
  logic          rf_we, fn_ok, dec_ok;
  logic [AW-1:0] rf_waddr;
  alu_op_e       alu_op;
  mem_req_t      mreq;

  assign sext = {{16{ir[15]}}, ir[15:0]};

  mips_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr1(ir[21 +: AW]), .raddr2(ir[16 +: AW]), .rdata1(rd1), .rdata2(rd2)
  );

  always_comb begin
    alu_op = ALU_ADD;
    fn_ok  = 1'b1;
    unique case (ir[5:0])
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: fn_ok  = 1'b0;
    endcase
  end

  always_comb begin
    dec_nx = FETCH;
    dec_ok = 1'b1;
    unique case (ir[31:26])
      OP_LW, OP_SW: dec_nx = MEMADR;
      OP_RTYPE:     begin dec_nx = REXEC; dec_ok = fn_ok; end
      OP_BEQ:       dec_nx = BEQEX;
      OP_J:         dec_nx = JEX;
`ifdef MIPS_MC_ADDI_EN
      OP_ADDI:      dec_nx = IEXEC;
`endif
      default:      dec_ok = 1'b0;
    endcase
    if (!dec_ok) dec_nx = FETCH;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:   if (mem_ready) state_nx = DECODE;
      DECODE:  state_nx = dec_nx;
      MEMADR:  state_nx = (ir[31:26] == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_nx = MEMWB;
      MEMWR:   if (mem_ready) state_nx = FETCH;
      REXEC:   state_nx = RWB;
`ifdef MIPS_MC_ADDI_EN
      IEXEC:   state_nx = IWB;
`endif
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    mreq     = '0;
    illegal  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = ir[16 +: AW];
    rf_wdata = mdr;
    unique case (state)
      FETCH:  begin mreq.req = 1'b1; mreq.addr = pc; end
      DECODE: illegal = !dec_ok;
      MEMRD:  begin mreq.req = 1'b1; mreq.addr = alu_out; end
      MEMWR:  begin mreq.req = 1'b1; mreq.we = 1'b1; mreq.addr = alu_out; mreq.wdata = b_q; end
      MEMWB:  rf_we = 1'b1;
      RWB:    begin rf_we = 1'b1; rf_waddr = ir[11 +: AW]; rf_wdata = alu_out; end
`ifdef MIPS_MC_ADDI_EN
      IWB:    begin rf_we = 1'b1; rf_wdata = alu_out; end
`endif
      default: ;
    endcase
  end

  // Gating with rst drops an in-flight access in the same cycle reset rises.
  assign mem_req   = mreq.req & ~rst;
  assign mem_we    = mreq.we & ~rst;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      unique case (state)
        FETCH:  if (mem_ready) begin ir <= mem_rdata; pc <= pc + 32'd4; end
        // Illegal instructions leave the operand and ALU registers untouched.
        DECODE: if (dec_ok) begin
                  a_q     <= rd1;
                  b_q     <= rd2;
                  alu_out <= pc + {sext[29:0], 2'b00};
                end
        MEMADR: alu_out <= a_q + sext;
        MEMRD:  if (mem_ready) mdr <= mem_rdata;
        REXEC:  alu_out <= alu(alu_op, a_q, b_q);
        BEQEX:  if (a_q == b_q) pc <= alu_out;
        JEX:    pc <= {pc[31:28], ir[25:0], 2'b00};
`ifdef MIPS_MC_ADDI_EN
        IEXEC:  alu_out <= a_q + sext;
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: ISA-level model checks every memory access and
// instruction latency; directed programs pin the model with literal results.
module tb_mips_multicycle;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  mips_multicycle #(.RESET_PC(RPC), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Memory: 1 KiB, one chosen access (by ordinal since reset) may be stalled.
  logic [31:0] mem [0:255];
  logic        ld_en = 1'b0, ld_clr = 1'b0;
  logic [7:0]  ld_idx = 8'h0;
  logic [31:0] ld_data = 32'h0;
  int acc_idx, wait_cnt, delay_idx = -1, delay_len = 0;

  assign mem_rdata = mem[mem_addr[9:2]];
  // Ready is held high while no request is pending; the core must ignore it.
  assign mem_ready = mem_req ? !(acc_idx == delay_idx && wait_cnt < delay_len) : 1'b1;

  always @(posedge clk) begin
    if (ld_clr) for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    else if (ld_en) mem[ld_idx] <= ld_data;
    else if (!rst && mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    if (rst) begin acc_idx <= 0; wait_cnt <= 0; end
    else if (mem_req) begin
      if (mem_ready) begin acc_idx <= acc_idx + 1; wait_cnt <= 0; end
      else wait_cnt <= wait_cnt + 1;
    end
  end

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = a[9:2]; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic clear_mem();
    ld_clr = 1'b1;
    @(posedge clk); #1;
    ld_clr = 1'b0;
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    logic [4:0] s, t, d;
    s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
    return {6'h00, s, t, d, 5'h0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    logic [4:0] s, t;
    s = rs[4:0]; t = rt[4:0];
    return {op, s, t, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  // ISA-level model: architectural regs/pc, next expected data access, latency table.
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc, pend_addr, pend_wdata, prev_addr, prev_wdata;
  bit          pend, pend_we, last_ill, prev_stall;
  logic        prev_we;
  int          since, stalls, last_n, cyc = 0, ill_cnt = 0;
  logic [31:0] flog [$];
  int          fcyc [$];

  function automatic void model_exec(input logic [31:0] ins, input logic [31:0] at);
    logic [31:0] sx, pc4, va, vb, res;
    int rs, rt, rd, wr;
    sx = {{16{ins[15]}}, ins[15:0]};
    pc4 = at + 32'd4;
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    va = m_regs[rs]; vb = m_regs[rt]; res = 32'h0; wr = -1;
    last_ill = 1'b0; m_pc = pc4;
    case (ins[31:26])
      6'h00: begin
        last_n = 4; wr = rd;
        case (ins[5:0])
          6'h20: res = va + vb;
          6'h22: res = va - vb;
          6'h24: res = va & vb;
          6'h25: res = va | vb;
          6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          default: begin wr = -1; last_ill = 1'b1; last_n = 2; end
        endcase
      end
      6'h23: begin
        last_n = 5; pend = 1'b1; pend_we = 1'b0; pend_addr = va + sx;
        res = mem[pend_addr[9:2]]; wr = rt;
      end
      6'h2B: begin last_n = 4; pend = 1'b1; pend_we = 1'b1; pend_addr = va + sx; pend_wdata = vb; end
      6'h04: begin last_n = 3; if (va == vb) m_pc = pc4 + (sx << 2); end
      6'h02: begin last_n = 3; m_pc = {pc4[31:28], ins[25:0], 2'b00}; end
`ifdef MIPS_MC_ADDI_EN
      6'h08: begin last_n = 4; res = va + sx; wr = rt; end
`endif
      default: begin last_ill = 1'b1; last_n = 2; end
    endcase
    if (wr > 0) m_regs[wr] = res;
  endfunction

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("req_low_in_reset", {31'h0, mem_req}, 32'h0);
        chk("illegal_low_in_reset", {31'h0, illegal}, 32'h0);
        m_pc = RPC; pend = 1'b0; since = 0; stalls = 0; last_n = 1; last_ill = 1'b0; prev_stall = 1'b0;
      end else begin
        since++;
        chk("illegal_pulse", {31'h0, illegal}, {31'h0, (since == 1) && last_ill});
        if (illegal) ill_cnt++;
        if (prev_stall) begin
          chk("stall_addr", mem_addr, prev_addr);
          chk("stall_we", {31'h0, mem_we}, {31'h0, prev_we});
          chk("stall_wdata", mem_wdata, prev_wdata);
        end
        if (mem_req && !mem_ready) stalls++;
        if (mem_req && mem_ready) begin
          if (pend) begin
            chk("data_addr", mem_addr, pend_addr);
            chk("data_we", {31'h0, mem_we}, {31'h0, pend_we});
            if (pend_we) chk("store_data", mem_wdata, pend_wdata);
            pend = 1'b0;
          end else begin
            chk("fetch_addr", mem_addr, m_pc);
            chk("fetch_we", {31'h0, mem_we}, 32'h0);
            chk("pc_out", pc, m_pc);
            chk("instr_cycles", since, last_n + stalls);
            flog.push_back(mem_addr);
            fcyc.push_back(cyc);
            model_exec(mem_rdata, mem_addr);
            since = 0; stalls = 0;
          end
        end
        prev_stall = mem_req && !mem_ready;
        prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
      end
    end
  end

  function automatic logic [31:0] next_after(input logic [31:0] a);
    for (int i = 0; i < flog.size() - 1; i++)
      if (flog[i] == a) return flog[i + 1];
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    int base, k;
    logic [31:0] exp_addi;
    int exp_ill;
    repeat (2) @(posedge clk); #1;
    // Program A: loads, stores, ALU ops, addi slot, jump to 0 and taken beq.
    clear_mem();
    poke(32'h100, enc_i(6'h23, 0, 2, 16'h0004));
    poke(32'h104, enc_i(6'h2B, 0, 2, 16'h0040));
    poke(32'h108, enc_i(6'h23, 0, 1, 16'h0208));
    poke(32'h10C, enc_i(6'h23, 0, 4, 16'h020C));
    poke(32'h110, enc_r(1, 4, 3, 6'h2A));
    poke(32'h114, enc_i(6'h2B, 0, 3, 16'h0044));
    poke(32'h118, enc_r(1, 4, 0, 6'h20));
    poke(32'h11C, enc_i(6'h2B, 0, 0, 16'h0048));
    poke(32'h120, enc_r(4, 1, 5, 6'h22));
    poke(32'h124, enc_i(6'h2B, 0, 5, 16'h004C));
    poke(32'h128, enc_i(6'h23, 0, 8, 16'h0210));
    poke(32'h12C, enc_i(6'h08, 0, 8, 16'h0007));
    poke(32'h130, enc_i(6'h2B, 0, 8, 16'h0050));
    poke(32'h134, enc_r(1, 4, 6, 6'h24));
    poke(32'h138, enc_r(5, 4, 7, 6'h25));
    poke(32'h13C, enc_i(6'h2B, 0, 6, 16'h0054));
    poke(32'h140, enc_i(6'h2B, 0, 7, 16'h0058));
    poke(32'h144, enc_i(6'h23, 0, 1, 16'h0214));
    poke(32'h148, enc_i(6'h23, 0, 2, 16'h0214));
    poke(32'h14C, enc_j(26'h0));
    poke(32'h000, enc_i(6'h04, 1, 2, 16'h0002));
    poke(32'h004, 32'hDEAD_BEEF);
    poke(32'h00C, enc_i(6'h04, 0, 0, 16'hFFFF));
    poke(32'h048, 32'h0000_0055);
    poke(32'h208, 32'hFFFF_FFFF);
    poke(32'h20C, 32'h0000_0001);
    poke(32'h210, 32'h0000_1234);
    poke(32'h214, 32'h0000_0005);
    delay_idx = 1; delay_len = 3;
    @(posedge clk); #2 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
`ifdef MIPS_MC_ADDI_EN
    exp_addi = 32'h7; exp_ill = 0;
`else
    exp_addi = 32'h1234; exp_ill = 1;
`endif
    chk("first_fetch", (flog.size() > 1) ? flog[0] : 32'hFFFF_FFFF, 32'h100);
    chk("second_fetch", (flog.size() > 1) ? flog[1] : 32'hFFFF_FFFF, 32'h104);
    chk("lw_stall_cycles", (fcyc.size() > 1) ? fcyc[1] - fcyc[0] : -1, 8);
    chk("lw_value", rdm(32'h40), 32'hDEAD_BEEF);
    chk("slt_signed", rdm(32'h44), 32'h1);
    chk("r0_zero", rdm(32'h48), 32'h0);
    chk("sub_wrap", rdm(32'h4C), 32'h2);
    chk("addi_slot", rdm(32'h50), exp_addi);
    chk("and_result", rdm(32'h54), 32'h1);
    chk("or_result", rdm(32'h58), 32'h3);
    chk("beq_taken_next", next_after(32'h0), 32'hC);
    chk("illegal_count", ill_cnt, exp_ill);

    // Program B: beq not taken, then reset during a stalled store.
    rst = 1'b1; delay_idx = -1;
    @(posedge clk); #1;
    flog.delete(); fcyc.delete(); ill_cnt = 0;
    clear_mem();
    poke(32'h100, enc_i(6'h23, 0, 1, 16'h0214));
    poke(32'h104, enc_i(6'h23, 0, 2, 16'h0218));
    poke(32'h108, enc_j(26'h0));
    poke(32'h000, enc_i(6'h04, 1, 2, 16'h0002));
    poke(32'h004, enc_i(6'h2B, 0, 1, 16'h0060));
    poke(32'h008, enc_i(6'h04, 0, 0, 16'hFFFF));
    poke(32'h060, 32'h0000_A5A5);
    poke(32'h214, 32'h0000_0005);
    poke(32'h218, 32'h0000_0006);
    delay_idx = 7; delay_len = 50;
    @(posedge clk); #2 rst = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) break;
    end
    chk("store_started", {31'h0, mem_req && mem_we}, 32'h1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("req_drops_on_rst", {31'h0, mem_req}, 32'h0);
    base = flog.size();
    chk("beq_not_taken_next", next_after(32'h0), 32'h4);
    repeat (3) @(posedge clk);
    #1 chk("store_abandoned", rdm(32'h60), 32'h0000_A5A5);
    delay_idx = -1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("refetch_reset_pc", (flog.size() > base) ? flog[base] : 32'hFFFF_FFFF, RPC);
    chk("store_after_restart", rdm(32'h60), 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
